usb_packet_parser: RTL and testbench

Packet-level consumer sitting directly downstream of the USB receiver's RX FIFO. Pops bytes whenever the FIFO is non-empty, validates the PID, classifies the packet, and streams payload bytes out. For data packets it withholds and checks the trailing CRC16. It reports one completion status per packet, using the receiver's `rcving` and `r_error` status lines to delimit and qualify packets.

---
 rtl/usb_pkt_pkg.sv | 27 ++
 rtl/usb_crc16_byte.sv | 18 +
 rtl/usb_packet_parser.sv | 143 ++++++++++++++
 tb/tb_usb_packet_parser.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkt_pkg.sv
// Shared types and constants for the USB packet parser: FSM states,
// PID classes, completion codes and CRC16 parameters.
package usb_pkt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BODY   = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  // PID[1:0] packet classes
  localparam logic [1:0] PT_SPECIAL   = 2'b00;
  localparam logic [1:0] PT_TOKEN     = 2'b01;
  localparam logic [1:0] PT_HANDSHAKE = 2'b10;
  localparam logic [1:0] PT_DATA      = 2'b11;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_PID = 2'b01;
  localparam logic [1:0] ERR_CRC = 2'b10;
  localparam logic [1:0] ERR_LEN = 2'b11;

  localparam logic [15:0] CRC16_POLY     = 16'hA001;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'hB001;

endpackage

// File: rtl/usb_crc16_byte.sv
// One-byte step of the reflected USB CRC16, bits consumed LSB first.
module usb_crc16_byte
  import usb_pkt_pkg::*;
(
  input  logic [15:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [15:0] crc_o
);

  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[0] ^ data_i[i]) crc_o = (crc_o >> 1) ^ CRC16_POLY;
      else                      crc_o = crc_o >> 1;
    end
  end

endmodule

// File: rtl/usb_packet_parser.sv
// Pops the USB RX FIFO, validates and classifies each packet, streams
// payload bytes (withholding the data CRC) and reports one status per packet.
module usb_packet_parser
  import usb_pkt_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       empty,
  input  logic [7:0] r_data,
  input  logic       rcving,
  input  logic       r_error,
  output logic       r_enable,
  output logic       pkt_start,
  output logic [3:0] pid,
  output logic       pay_valid,
  output logic [7:0] pay_data,
  output logic       pkt_done,
  output logic       pkt_ok,
  output logic [1:0] err_code
);

  state_t      state_q;
  logic [3:0]  pid_q;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  hold_old_q, hold_new_q;
  logic [1:0]  hold_cnt_q;
  logic [2:0]  cnt_q, cnt_d;
  logic        rx_err_q, pid_err_q;
  logic        pkt_start_q, pay_valid_q, pkt_done_q, pkt_ok_q;
  logic [7:0]  pay_data_q;
  logic [1:0]  err_code_q, err_d;
  logic [1:0]  ptype;
  logic        pid_valid, pkt_end, len_bad;

  assign r_enable  = (state_q != ST_FINISH) && !empty;
  assign pid_valid = (r_data[7:4] == ~r_data[3:0]);
  assign pkt_end   = !rcving && empty;
  assign ptype     = pid_q[1:0];
  assign cnt_d     = (cnt_q == 3'd7) ? 3'd7 : cnt_q + 3'd1;

  usb_crc16_byte u_crc (
    .crc_i  (crc_q),
    .data_i (r_data),
    .crc_o  (crc_d)
  );

  always_comb begin
    len_bad = 1'b0;
    unique case (ptype)
      PT_DATA:      len_bad = (cnt_q < 3'd2);
      PT_HANDSHAKE: len_bad = (cnt_q != 3'd0);
      default:      len_bad = (cnt_q != 3'd2);
    endcase
  end

  // r_error is folded in directly so an error in the end cycle still counts
  always_comb begin
    err_d = ERR_OK;
    if (pid_err_q)                                    err_d = ERR_PID;
    else if (rx_err_q || r_error || len_bad)          err_d = ERR_LEN;
    else if (ptype == PT_DATA && crc_q != CRC16_RESIDUAL) err_d = ERR_CRC;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      pid_q       <= '0;
      crc_q       <= CRC16_INIT;
      hold_old_q  <= '0;
      hold_new_q  <= '0;
      hold_cnt_q  <= '0;
      cnt_q       <= '0;
      rx_err_q    <= 1'b0;
      pid_err_q   <= 1'b0;
      pkt_start_q <= 1'b0;
      pay_valid_q <= 1'b0;
      pay_data_q  <= '0;
      pkt_done_q  <= 1'b0;
      pkt_ok_q    <= 1'b0;
      err_code_q  <= '0;
    end else begin
      pkt_start_q <= 1'b0;
      pay_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (r_enable) begin
          cnt_q      <= '0;
          crc_q      <= CRC16_INIT;
          hold_cnt_q <= '0;
          rx_err_q   <= 1'b0;
          if (pid_valid) begin
            pid_q       <= r_data[3:0];
            pkt_start_q <= 1'b1;
            pid_err_q   <= 1'b0;
            state_q     <= ST_BODY;
          end else begin
            pid_err_q <= 1'b1;
            state_q   <= ST_DRAIN;
          end
        end
        ST_BODY, ST_DRAIN: begin
          if (r_error) rx_err_q <= 1'b1;
          if (pkt_end) begin
            state_q    <= ST_FINISH;
            pkt_done_q <= 1'b1;
            err_code_q <= err_d;
            pkt_ok_q   <= (err_d == ERR_OK);
          end else if (r_enable) begin
            cnt_q <= cnt_d;
            if (state_q == ST_BODY) begin
              if (ptype == PT_DATA) begin
                // two-byte holdoff keeps the trailing CRC off pay_data
                crc_q      <= crc_d;
                hold_new_q <= r_data;
                hold_old_q <= hold_new_q;
                if (hold_cnt_q == 2'd2) begin
                  pay_valid_q <= 1'b1;
                  pay_data_q  <= hold_old_q;
                end else begin
                  hold_cnt_q <= hold_cnt_q + 2'd1;
                end
              end else if (ptype != PT_HANDSHAKE) begin
                pay_valid_q <= 1'b1;
                pay_data_q  <= r_data;
              end
            end
          end
        end
        ST_FINISH: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign pkt_start = pkt_start_q;
  assign pid       = pid_q;
  assign pay_valid = pay_valid_q;
  assign pay_data  = pay_data_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_ok    = pkt_ok_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_usb_packet_parser.sv
// Scoreboard bench for usb_packet_parser: a FIFO model feeds directed packets,
// expectations are queued at issue time and a monitor checks DUT outputs.
module tb_usb_packet_parser;

  logic       clk = 1'b0;
  logic       n_rst, empty, rcving, r_error;
  logic [7:0] r_data;
  logic       r_enable, pkt_start, pay_valid, pkt_done, pkt_ok;
  logic [3:0] pid;
  logic [7:0] pay_data;
  logic [1:0] err_code;

  usb_packet_parser dut (
    .clk(clk), .n_rst(n_rst), .empty(empty), .r_data(r_data),
    .rcving(rcving), .r_error(r_error), .r_enable(r_enable),
    .pkt_start(pkt_start), .pid(pid), .pay_valid(pay_valid),
    .pay_data(pay_data), .pkt_done(pkt_done), .pkt_ok(pkt_ok),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_done = 0;
  bit stall_en = 1'b0;

  logic [7:0] fifo[$];
  logic [3:0] exp_pid_q[$];
  logic [7:0] exp_pay_q[$];
  logic [1:0] exp_err_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < 8; k++) begin
      logic fb;
      fb = r[0] ^ b[k];
      r  = {1'b0, r[15:1]};
      if (fb) r = r ^ 16'hA001;
    end
    return r;
  endfunction

  // FIFO model: pops on the edge where r_enable was high, redrives at +1
  initial begin
    bit pop_now;
    bit tog;
    tog    = 1'b0;
    empty  = 1'b1;
    r_data = 8'h00;
    forever begin
      @(negedge clk);
      pop_now = r_enable;
      @(posedge clk);
      #1;
      if (pop_now && fifo.size() > 0) void'(fifo.pop_front());
      tog    = ~tog;
      empty  = (fifo.size() == 0) || (stall_en && tog);
      r_data = (fifo.size() > 0) ? fifo[0] : 8'h00;
    end
  end

  // Monitor
  always @(negedge clk) begin
    if (n_rst === 1'b1) begin
      if (pkt_start) begin
        if (exp_pid_q.size() == 0) fail_now("unexpected_pkt_start");
        else check("pid", pid, exp_pid_q.pop_front());
      end
      if (pay_valid) begin
        if (exp_pay_q.size() == 0) fail_now("unexpected_pay_valid");
        else check("pay_data", pay_data, exp_pay_q.pop_front());
      end
      if (pkt_done) begin
        n_done++;
        if (exp_err_q.size() == 0) fail_now("unexpected_pkt_done");
        else begin
          logic [1:0] e;
          e = exp_err_q.pop_front();
          check("err_code", err_code, e);
          check("pkt_ok", pkt_ok, (e == 2'b00));
        end
      end
    end
  end

  // Send whatever is queued in the FIFO as one packet, then await pkt_done
  task automatic run_pkt(input bit rerr);
    int d0;
    d0 = n_done;
    rcving = 1'b1;
    if (rerr) begin
      tick(); tick();
      r_error = 1'b1;
      tick();
      r_error = 1'b0;
    end
    for (int i = 0; i < 200 && fifo.size() > 0; i++) tick();
    if (fifo.size() > 0) fail_now("fifo_drain_timeout");
    tick();
    rcving = 1'b0;
    for (int i = 0; i < 20 && n_done == d0; i++) tick();
    check("pkt_done_seen", n_done, d0 + 1);
    repeat (3) tick();
  endtask

  task automatic push_data1();
    logic [15:0] c;
    c = 16'hFFFF;
    fifo.push_back(8'h4B);
    for (int i = 0; i < 4; i++) begin
      fifo.push_back(8'(i));
      exp_pay_q.push_back(8'(i));
      c = crc_upd(c, 8'(i));
    end
    c = ~c;
    fifo.push_back(c[7:0]);
    fifo.push_back(c[15:8]);
    exp_pid_q.push_back(4'hB);
    exp_err_q.push_back(2'b00);
  endtask

  initial begin
    int d0;
    n_rst   = 1'b0;
    rcving  = 1'b0;
    r_error = 1'b0;
    repeat (3) tick();
    check("rst_r_enable", r_enable, 0);
    check("rst_pkt_start", pkt_start, 0);
    check("rst_pid", pid, 0);
    check("rst_pay_valid", pay_valid, 0);
    check("rst_pay_data", pay_data, 0);
    check("rst_pkt_done", pkt_done, 0);
    check("rst_pkt_ok", pkt_ok, 0);
    check("rst_err_code", err_code, 0);
    n_rst = 1'b1;
    tick();

    // ACK
    fifo.push_back(8'hD2);
    exp_pid_q.push_back(4'h2); exp_err_q.push_back(2'b00);
    run_pkt(1'b0);

    // DATA0 zero length, good and bad CRC
    fifo.push_back(8'hC3); fifo.push_back(8'h00); fifo.push_back(8'h00);
    exp_pid_q.push_back(4'h3); exp_err_q.push_back(2'b00);
    run_pkt(1'b0);
    fifo.push_back(8'hC3); fifo.push_back(8'h00); fifo.push_back(8'h01);
    exp_pid_q.push_back(4'h3); exp_err_q.push_back(2'b10);
    run_pkt(1'b0);

    // DATA1 four bytes, then again with empty stalls
    push_data1();
    run_pkt(1'b0);
    push_data1();
    stall_en = 1'b1;
    run_pkt(1'b0);
    stall_en = 1'b0;

    // Bad PID drains the rest
    fifo.push_back(8'hC4); fifo.push_back(8'h11); fifo.push_back(8'h22);
    exp_err_q.push_back(2'b01);
    run_pkt(1'b0);
    check("badpid_drained", fifo.size(), 0);

    // Token OUT, complete and short
    fifo.push_back(8'hE1); fifo.push_back(8'h05); fifo.push_back(8'h08);
    exp_pid_q.push_back(4'h1); exp_pay_q.push_back(8'h05); exp_pay_q.push_back(8'h08);
    exp_err_q.push_back(2'b00);
    run_pkt(1'b0);
    fifo.push_back(8'hE1); fifo.push_back(8'h05);
    exp_pid_q.push_back(4'h1); exp_pay_q.push_back(8'h05); exp_err_q.push_back(2'b11);
    run_pkt(1'b0);

    // Receiver error during a valid DATA0
    fifo.push_back(8'hC3); fifo.push_back(8'h00); fifo.push_back(8'h00);
    exp_pid_q.push_back(4'h3); exp_err_q.push_back(2'b11);
    run_pkt(1'b1);

    // Reset mid-BODY abandons the packet
    fifo.push_back(8'hC3); fifo.push_back(8'h01);
    exp_pid_q.push_back(4'h3);
    rcving = 1'b1;
    for (int i = 0; i < 20 && fifo.size() > 0; i++) tick();
    tick(); tick();
    d0 = n_done;
    n_rst  = 1'b0;
    rcving = 1'b0;
    fifo.delete();
    tick(); tick();
    check("midrst_pkt_done", pkt_done, 0);
    check("midrst_pid", pid, 0);
    n_rst = 1'b1;
    repeat (6) tick();
    check("no_done_after_reset", n_done, d0);
    fifo.push_back(8'hD2);
    exp_pid_q.push_back(4'h2); exp_err_q.push_back(2'b00);
    run_pkt(1'b0);

    check("leftover_pid", exp_pid_q.size(), 0);
    check("leftover_pay", exp_pay_q.size(), 0);
    check("leftover_done", exp_err_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
